alu_arbiter: RTL

Shares the single clocked 32-bit ALU (ADD/SUB/OR, zero and overflow flags) between two requesters. Each request uses a valid/ready handshake. Arbitration is round-robin. The block drives the ALU operand/control inputs from registers, waits out the ALU's registered latency, and returns each result on one response channel tagged with the requester id. It sits between the ALU and its two users, for example the datapath sequencer and a debug/test port.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_rr_pick.sv | 27 ++
 rtl/alu_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM state encoding and
// datapath width.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_OR  = 2'b10,
    ALU_ILL = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  function automatic logic is_illegal(input logic [1:0] ctrl);
    return (ctrl == ALU_ILL);
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: on contention the requester that was not served
// last wins; a lone requester always wins.
module alu_rr_pick
  import alu_pkg::*;
(
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic grant_o,
  output logic any_o
);

  // Grant index selection
  always_comb begin
    grant_o = 1'b0;
    if (valid0_i && valid1_i) begin
      grant_o = ~last_i;
    end else if (valid1_i) begin
      grant_o = 1'b1;
    end else begin
      grant_o = 1'b0;
    end
  end

  assign any_o = valid0_i | valid1_i;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered-latency ALU between two valid/ready requesters and
// returns each result, tagged with the requester id, on a single response port.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_da,
  input  logic [DATA_W-1:0] req0_db,
  input  logic [1:0]        req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_da,
  input  logic [DATA_W-1:0] req1_db,
  input  logic [1:0]        req1_ctrl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_dc,
  output logic              rsp_zero,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_da,
  output logic [DATA_W-1:0] alu_db,
  output logic [1:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_dc,
  input  logic              alu_zero,
  input  logic              alu_ovf
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              id_q, id_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] alu_da_q, alu_da_d;
  logic [DATA_W-1:0] alu_db_q, alu_db_d;
  logic [1:0]        alu_ctrl_q, alu_ctrl_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_dc_q, rsp_dc_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              rsp_err_q, rsp_err_d;

  logic              grant;
  logic              any_valid;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_da;
  logic [DATA_W-1:0] sel_db;
  logic [1:0]        sel_ctrl;
  logic              accept;

  alu_rr_pick u_pick (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .last_i   (last_q),
    .grant_o  (grant),
    .any_o    (any_valid)
  );

  assign sel_valid = grant ? req1_valid : req0_valid;
  assign sel_da    = grant ? req1_da    : req0_da;
  assign sel_db    = grant ? req1_db    : req0_db;
  assign sel_ctrl  = grant ? req1_ctrl  : req0_ctrl;
  assign accept    = (state_q == ST_IDLE) && any_valid && sel_valid;

  assign req0_ready = (state_q == ST_IDLE) && !grant && req0_valid;
  assign req1_ready = (state_q == ST_IDLE) &&  grant && req1_valid;

  // Next-state, counter and datapath register updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    id_d        = id_q;
    err_d       = err_q;
    alu_da_d    = alu_da_q;
    alu_db_d    = alu_db_q;
    alu_ctrl_d  = alu_ctrl_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_dc_d    = rsp_dc_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d    = grant;
          last_d  = grant;
          cnt_d   = CNT_W'(ALU_LAT);
          err_d   = is_illegal(sel_ctrl);
          state_d = ST_WAIT;
          // An illegal op leaves the ALU inputs on the previous operation.
          if (!is_illegal(sel_ctrl)) begin
            alu_da_d   = sel_da;
            alu_db_d   = sel_db;
            alu_ctrl_d = sel_ctrl;
          end else begin
            alu_da_d   = alu_da_q;
            alu_db_d   = alu_db_q;
            alu_ctrl_d = alu_ctrl_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          state_d     = ST_RESP;
          if (err_q) begin
            rsp_dc_d   = {DATA_W{1'b0}};
            rsp_zero_d = 1'b0;
            rsp_ovf_d  = 1'b0;
            rsp_err_d  = 1'b1;
          end else begin
            rsp_dc_d   = alu_dc;
            rsp_zero_d = alu_zero;
            rsp_ovf_d  = alu_ovf;
            rsp_err_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      err_q       <= 1'b0;
      alu_da_q    <= {DATA_W{1'b0}};
      alu_db_q    <= {DATA_W{1'b0}};
      alu_ctrl_q  <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_dc_q    <= {DATA_W{1'b0}};
      rsp_zero_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      id_q        <= id_d;
      err_q       <= err_d;
      alu_da_q    <= alu_da_d;
      alu_db_q    <= alu_db_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_dc_q    <= rsp_dc_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_da    = alu_da_q;
  assign alu_db    = alu_db_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_dc    = rsp_dc_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;

endmodule
